// File: rtl/load_shuffle_unit_pkg.sv
// Shared types, sizing and the lane shuffle index function for the
// vector load shuffle path.
package load_shuffle_unit_pkg;

  localparam int unsigned NrLane    = 4;
  localparam int unsigned ByteBlock = NrLane * 8;
  localparam int unsigned OffW      = $clog2(ByteBlock);
  localparam int unsigned VlenW     = 16;

  typedef logic [VlenW-1:0] vlen_t;
  typedef logic [OffW-1:0]  off_t;
  typedef logic [63:0]      vrf_data_t;
  typedef logic [7:0]       vrf_strb_t;

  typedef enum logic [1:0] {
    EW8, EW16, EW32, EW64
  } vew_e;

  typedef enum logic [1:0] {
    IDLE, RUN, TAIL
  } lsu_state_e;

  // Element e lands in lane e mod NrLane, packed by e / NrLane.
  function automatic int unsigned shuffle_idx(
    input int unsigned nr_lane,
    input vew_e        sew,
    input int unsigned k
  );
    int unsigned b;
    int unsigned e;
    b = 32'd1 << sew;
    e = k >> sew;
    return (e % nr_lane) * 8 + (e / nr_lane) * b + (k % b);
  endfunction

endpackage

// File: rtl/load_shuffle_unit_if.sv
// Request, memory-beat and lane write-back handshakes of the
// load shuffle unit.
interface load_shuffle_unit_if;
  import load_shuffle_unit_pkg::*;

  logic                   req_valid_i;
  logic                   req_ready_o;
  vlen_t                  req_bytes_i;
  off_t                   req_offset_i;
  vew_e                   req_sew_i;
  logic                   mem_valid_i;
  logic                   mem_ready_o;
  vrf_data_t [NrLane-1:0] mem_data_i;
  logic                   vrf_valid_o;
  logic                   vrf_ready_i;
  vrf_data_t [NrLane-1:0] vrf_data_o;
  vrf_strb_t [NrLane-1:0] vrf_strb_o;
  logic                   done_o;

  modport slave (
    input  req_valid_i, req_bytes_i, req_offset_i, req_sew_i,
    input  mem_valid_i, mem_data_i, vrf_ready_i,
    output req_ready_o, mem_ready_o,
    output vrf_valid_o, vrf_data_o, vrf_strb_o, done_o
  );

  modport master (
    output req_valid_i, req_bytes_i, req_offset_i, req_sew_i,
    output mem_valid_i, mem_data_i, vrf_ready_i,
    input  req_ready_o, mem_ready_o,
    input  vrf_valid_o, vrf_data_o, vrf_strb_o, done_o
  );

endinterface

// File: rtl/load_shuffle_unit_mem_shuffler.sv
// Combinational byte/strobe permutation from aligned order into
// the lane-interleaved VRF layout.
module mem_shuffler
  import load_shuffle_unit_pkg::*;
(
  input  logic [ByteBlock*8-1:0] data_i,
  input  logic [ByteBlock-1:0]   strb_i,
  input  vew_e                   sew_i,
  output logic [ByteBlock*8-1:0] data_o,
  output logic [ByteBlock-1:0]   strb_o
);

  always_comb begin : perm
    off_t idx;
    idx    = '0;
    data_o = '0;
    strb_o = '0;
    for (int k = 0; k < ByteBlock; k++) begin
      idx = OffW'(shuffle_idx(NrLane, sew_i, k));
      data_o[{idx, 3'b000} +: 8] = data_i[k*8 +: 8];
      strb_o[idx]                = strb_i[k];
    end
  end

endmodule

// File: rtl/load_shuffle_unit.sv
// Realigns unit-stride load beats to the start offset and shuffles
// them into per-lane VRF words behind one output register.
module load_shuffle_unit
  import load_shuffle_unit_pkg::*;
(
  input logic                 clk_i,
  input logic                 rst_ni,
  load_shuffle_unit_if.slave  bus
);

  localparam int unsigned W = ByteBlock * 8;

  lsu_state_e           state_q;
  vlen_t                beats_q;
  vlen_t                words_q;
  off_t                 off_q;
  off_t                 rem_q;
  vew_e                 sew_q;
  logic [W-1:0]         hold_q;
  logic                 hold_vld_q;
  logic                 out_vld_q;
  logic                 out_last_q;
  logic                 zero_done_q;
  logic [W-1:0]         out_data_q;
  logic [ByteBlock-1:0] out_strb_q;

  logic [W-1:0]         beat;
  logic [W-1:0]         aligned;
  logic [W-1:0]         shuf_data;
  logic [ByteBlock-1:0] aln_strb;
  logic [ByteBlock-1:0] shuf_strb;
  logic [OffW+2:0]      sh_lo;
  logic [OffW+3:0]      sh_hi;
  logic [VlenW:0]       beats_sum;
  logic [VlenW:0]       words_sum;
  logic                 out_free;
  logic                 fin;
  logic                 mem_rdy;
  logic                 mem_hs;
  logic                 req_rdy;
  logic                 req_hs;
  logic                 tail_go;
  logic                 produce;
  logic                 last;

  assign beat     = bus.mem_data_i;
  assign out_free = !out_vld_q || bus.vrf_ready_i;
  assign fin      = out_vld_q && bus.vrf_ready_i && out_last_q;
  assign req_rdy  = (state_q == IDLE) && !zero_done_q;
  assign req_hs   = bus.req_valid_i && req_rdy;
  assign mem_rdy  = (state_q == RUN) && (beats_q != '0) && out_free;
  assign mem_hs   = bus.mem_valid_i && mem_rdy;
  assign tail_go  = (state_q == TAIL) && (words_q == vlen_t'(1))
                    && out_free;
  assign produce  = (mem_hs && ((off_q == '0) || hold_vld_q))
                    || tail_go;
  assign last     = (words_q == vlen_t'(1));

  assign bus.req_ready_o = req_rdy;
  assign bus.mem_ready_o = mem_rdy;
  assign bus.vrf_valid_o = out_vld_q;
  assign bus.vrf_data_o  = out_data_q;
  assign bus.vrf_strb_o  = out_strb_q;
  assign bus.done_o      = fin || zero_done_q;

  assign beats_sum = {1'b0, bus.req_bytes_i}
                   + (VlenW+1)'(bus.req_offset_i)
                   + (VlenW+1)'(ByteBlock - 1);
  assign words_sum = {1'b0, bus.req_bytes_i}
                   + (VlenW+1)'(ByteBlock - 1);

  assign sh_lo = {off_q, 3'b000};
  assign sh_hi = (OffW+4)'(W) - {1'b0, sh_lo};

  // TAIL drains the holder alone; its upper bytes are never strobed.
  always_comb begin
    aligned = '0;
    if (off_q == '0) begin
      aligned = beat;
    end else if (state_q == TAIL) begin
      aligned = hold_q >> sh_lo;
    end else begin
      aligned = (hold_q >> sh_lo) | (beat << sh_hi);
    end
  end

  always_comb begin
    aln_strb = '0;
    for (int k = 0; k < ByteBlock; k++) begin
      aln_strb[k] = !last || (rem_q == '0) || (k < int'(rem_q));
    end
  end

  mem_shuffler i_mem_shuffler (
    .data_i (aligned),
    .strb_i (aln_strb),
    .sew_i  (sew_q),
    .data_o (shuf_data),
    .strb_o (shuf_strb)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      beats_q     <= '0;
      words_q     <= '0;
      off_q       <= '0;
      rem_q       <= '0;
      sew_q       <= EW8;
      hold_q      <= '0;
      hold_vld_q  <= 1'b0;
      out_vld_q   <= 1'b0;
      out_last_q  <= 1'b0;
      zero_done_q <= 1'b0;
      out_data_q  <= '0;
      out_strb_q  <= '0;
    end else begin
      zero_done_q <= 1'b0;

      if (produce) begin
        out_vld_q  <= 1'b1;
        out_data_q <= shuf_data;
        out_strb_q <= shuf_strb;
        out_last_q <= last;
        words_q    <= words_q - vlen_t'(1);
      end else if (bus.vrf_ready_i) begin
        out_vld_q <= 1'b0;
      end

      if (mem_hs) begin
        beats_q <= beats_q - vlen_t'(1);
        if (off_q != '0) begin
          hold_q     <= beat;
          hold_vld_q <= 1'b1;
        end
      end

      unique case (state_q)
        IDLE: begin
          if (req_hs) begin
            if (bus.req_bytes_i == '0) begin
              zero_done_q <= 1'b1;
            end else begin
              off_q      <= bus.req_offset_i;
              rem_q      <= bus.req_bytes_i[OffW-1:0];
              sew_q      <= bus.req_sew_i;
              beats_q    <= vlen_t'(beats_sum >> OffW);
              words_q    <= vlen_t'(words_sum >> OffW);
              hold_vld_q <= 1'b0;
              state_q    <= RUN;
            end
          end
        end
        RUN: begin
          if (fin) begin
            state_q <= IDLE;
          end else if ((beats_q == '0) && last && hold_vld_q) begin
            state_q <= TAIL;
          end
        end
        TAIL: begin
          if (fin) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_shuffle_unit.sv
// Directed bench for load_shuffle_unit with an address-based
// reference for every lane byte.
module tb_load_shuffle_unit;
  import load_shuffle_unit_pkg::*;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  int   checks = 0;
  int   failures = 0;

  logic [63:0] cap_d [0:15][0:NrLane-1];
  logic [7:0]  cap_s [0:15][0:NrLane-1];

  always #5 clk = ~clk;

  load_shuffle_unit_if bus ();

  load_shuffle_unit dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [ByteBlock*8-1:0] mk_beat(input int n,
                                                     input int seed);
    logic [ByteBlock*8-1:0] v;
    for (int b = 0; b < ByteBlock; b++)
      v[b*8 +: 8] = 8'(n * ByteBlock + b + seed);
    return v;
  endfunction

  // Walk back from VRF byte to the memory address it came from.
  task automatic check_word(input int w, input int off, input int bytes,
                            input int sew, input int seed);
    logic [63:0] exp_d, mask, got_d;
    logic [7:0]  exp_s, got_s;
    int bb, q, r, e, k;
    bb = 1 << sew;
    for (int l = 0; l < NrLane; l++) begin
      exp_d = '0; mask = '0; exp_s = '0;
      for (int j = 0; j < 8; j++) begin
        q = j / bb; r = j % bb;
        e = q * NrLane + l;
        k = e * bb + r;
        if (w * ByteBlock + k < bytes) begin
          exp_s[j] = 1'b1;
          mask[j*8 +: 8] = 8'hff;
          exp_d[j*8 +: 8] = 8'(off + w * ByteBlock + k + seed);
        end
      end
      got_d = bus.vrf_data_o[l];
      got_s = bus.vrf_strb_o[l];
      cap_d[w][l] = got_d;
      cap_s[w][l] = got_s;
      chk($sformatf("w%0d_l%0d_data", w, l), got_d & mask, exp_d);
      chk($sformatf("w%0d_l%0d_strb", w, l), {56'd0, got_s},
          {56'd0, exp_s});
    end
  endtask

  task automatic run_load(input int bytes, input int off, input int sew,
                          input int seed, input int rdy_pct);
    int nb, nw, beats, words, dones, stall_bad, extra;
    logic rdy;
    nb = (off + bytes + ByteBlock - 1) / ByteBlock;
    nw = (bytes + ByteBlock - 1) / ByteBlock;
    beats = 0; words = 0; dones = 0; stall_bad = 0; extra = 0;
    for (int w = 0; w < 16; w++)
      for (int l = 0; l < NrLane; l++) begin
        cap_d[w][l] = '0; cap_s[w][l] = '0;
      end
    @(negedge clk);
    bus.req_valid_i  = 1'b1;
    bus.req_bytes_i  = vlen_t'(bytes);
    bus.req_offset_i = off_t'(off);
    bus.req_sew_i    = vew_e'(sew);
    #1;
    chk("req_ready", {63'd0, bus.req_ready_o}, 64'd1);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    for (int cyc = 0; cyc < 600 && !(words == nw && dones > 0); cyc++) begin
      bus.mem_valid_i = 1'b1;
      bus.mem_data_i  = mk_beat(beats, seed);
      rdy = ($urandom_range(99) < rdy_pct);
      bus.vrf_ready_i = rdy;
      #1;
      if (bus.vrf_valid_o && !rdy && bus.mem_ready_o) stall_bad++;
      if (bus.done_o) dones++;
      if (bus.vrf_valid_o && rdy) begin
        if (words < 16) check_word(words, off, bytes, sew, seed);
        chk($sformatf("w%0d_done", words), {63'd0, bus.done_o},
            {63'd0, words == nw - 1});
        words++;
      end
      if (bus.mem_valid_i && bus.mem_ready_o) beats++;
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      bus.vrf_ready_i = 1'b1;
      #1;
      if (bus.mem_ready_o) extra++;
      if (bus.vrf_valid_o) extra++;
      if (bus.done_o) dones++;
      @(negedge clk);
    end
    bus.mem_valid_i = 1'b0;
    chk("words", 64'(words), 64'(nw));
    chk("beats", 64'(beats), 64'(nb));
    chk("dones", 64'(dones), 64'd1);
    chk("stall_mem_ready", 64'(stall_bad), 64'd0);
    chk("extra_activity", 64'(extra), 64'd0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_req_ready"}, {63'd0, bus.req_ready_o}, 64'd1);
    chk({tag, "_mem_ready"}, {63'd0, bus.mem_ready_o}, 64'd0);
    chk({tag, "_vrf_valid"}, {63'd0, bus.vrf_valid_o}, 64'd0);
    chk({tag, "_done"}, {63'd0, bus.done_o}, 64'd0);
    chk({tag, "_data"}, bus.vrf_data_o[0] | bus.vrf_data_o[NrLane-1],
        64'd0);
    chk({tag, "_strb"}, {56'd0, bus.vrf_strb_o[0]}, 64'd0);
  endtask

  initial begin
    int zd, zhs, zv;
    bus.req_valid_i  = 1'b0;
    bus.req_bytes_i  = '0;
    bus.req_offset_i = '0;
    bus.req_sew_i    = EW8;
    bus.mem_valid_i  = 1'b0;
    bus.mem_data_i   = '0;
    bus.vrf_ready_i  = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_state("rst");
    rst_ni = 1'b1;

    run_load(64, 0, 0, 0, 100);
    chk("t1_w0_l0", cap_d[0][0], 64'h1c18_1410_0c08_0400);
    chk("t1_w0_l1", cap_d[0][1], 64'h1d19_1511_0d09_0501);
    chk("t1_w1_l0", cap_d[1][0], 64'h3c38_3430_2c28_2420);
    chk("t1_w1_s0", {56'd0, cap_s[1][0]}, 64'hff);

    run_load(40, 4, 2, 0, 100);
    chk("t2_w1_s0", {56'd0, cap_s[1][0]}, 64'h0f);
    chk("t2_w1_s1", {56'd0, cap_s[1][1]}, 64'h0f);
    chk("t2_w1_s2", {56'd0, cap_s[1][2]}, 64'h00);
    chk("t2_w1_d0", cap_d[1][0] & 64'hffff_ffff, 64'h2726_2524);

    run_load(2, 12, 1, 0, 100);
    chk("t3_d0", cap_d[0][0] & 64'hffff, 64'h0d0c);
    chk("t3_s0", {56'd0, cap_s[0][0]}, 64'h03);

    run_load(256, 8, 1, 8'h33, 50);
    run_load(100, 20, 3, 5, 100);

    // Zero-byte request.
    zd = 0; zhs = 0; zv = 0;
    @(negedge clk);
    bus.req_valid_i = 1'b1;
    bus.req_bytes_i = '0;
    bus.req_offset_i = off_t'(4);
    bus.mem_valid_i = 1'b1;
    bus.vrf_ready_i = 1'b1;
    #1;
    chk("z_req_ready", {63'd0, bus.req_ready_o}, 64'd1);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (bus.done_o) begin
        zd++;
        chk("z_req_ready_at_done", {63'd0, bus.req_ready_o}, 64'd0);
      end
      if (bus.mem_ready_o) zhs++;
      if (bus.vrf_valid_o) zv++;
      @(negedge clk);
    end
    bus.mem_valid_i = 1'b0;
    chk("z_dones", 64'(zd), 64'd1);
    chk("z_mem_hs", 64'(zhs), 64'd0);
    chk("z_vrf_valid", 64'(zv), 64'd0);

    // Reset in the middle of a load, then a fresh load.
    @(negedge clk);
    bus.req_valid_i = 1'b1;
    bus.req_bytes_i = vlen_t'(96);
    bus.req_offset_i = off_t'(8);
    bus.req_sew_i = EW32;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    bus.vrf_ready_i = 1'b0;
    bus.mem_valid_i = 1'b1;
    bus.mem_data_i = mk_beat(0, 8'h11);
    @(negedge clk);
    bus.mem_data_i = mk_beat(1, 8'h11);
    @(negedge clk);
    #1;
    chk("mid_vrf_valid", {63'd0, bus.vrf_valid_o}, 64'd1);
    rst_ni = 1'b0;
    #1;
    chk_reset_state("mid_rst");
    @(negedge clk);
    bus.mem_valid_i = 1'b0;
    rst_ni = 1'b1;
    run_load(40, 4, 0, 8'h80, 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_shuffle_unit.md
# load_shuffle_unit

Load-path data realigner and lane shuffler for vector unit-stride loads. It accepts memory beats in plain byte order from the memory interface and aligns them to the load's start offset. It then permutes bytes into the lane-interleaved VRF layout and emits per-lane data plus byte strobes to the lane write-back path. It is the load-side inverse of the store-side deshuffler.

## Interface
- Parameters: none local; `NrLane` (1/2/4/8/16) and `ByteBlock` (= `NrLane`*8) come from `core_pkg`, VRF word width fixed at 64 bits.
- `clk_i` input 1: clock.
- `rst_ni` input 1: reset, asynchronous, active-low.
- `req_valid_i` input 1: load request valid.
- `req_ready_o` output 1: request accepted; high only in IDLE.
- `req_bytes_i` input `vlen_t`: total bytes to load (vl * element bytes).
- `req_offset_i` input `$clog2(ByteBlock)`: start byte offset within the first memory beat.
- `req_sew_i` input `vew_e`: element width EW8/16/32/64.
- `mem_valid_i` input 1: memory beat valid.
- `mem_ready_o` output 1: memory beat accepted.
- `mem_data_i` input `vrf_data_t [NrLane-1:0]`: ByteBlock-aligned beat, byte k at bit 8k.
- `vrf_valid_o` output 1: output word valid.
- `vrf_ready_i` input 1: lanes accept output word.
- `vrf_data_o` output `vrf_data_t [NrLane-1:0]`: shuffled data.
- `vrf_strb_o` output `vrf_strb_t [NrLane-1:0]`: shuffled byte enables.
- `done_o` output 1: one-cycle pulse on the final output handshake, or the cycle after accepting a zero-byte request.

## Operation
- States: IDLE, RUN, TAIL.
- IDLE to RUN on request handshake. The unit latches bytes, offset, sew, and sets `beats_left` = ceil((offset+bytes)/ByteBlock) and `words_left` = ceil(bytes/ByteBlock). `bytes`=0: stays in IDLE and pulses `done_o` the next cycle.
- Realignment: aligned word n = bytes [offset, ByteBlock) of beat n concatenated with bytes [0, offset) of beat n+1. A holding register keeps the previous beat.
  - offset=0: no holding; each beat yields one word.
  - offset≠0: the first beat only fills the holder, and each later beat yields one word.
- RUN to TAIL when `beats_left` reaches 0 while `words_left`=1 and the holder has data not yet emitted. TAIL emits that word from the holder alone, with no memory beat.
- Shuffle: aligned byte k, with element bytes B=2^sew and element e=k/B, goes to VRF byte (e mod NrLane)*8 + (e/NrLane)*B + k mod B. The strobe is permuted identically.
- Strobe is all-ones except on the last word, where aligned bytes k < (bytes mod ByteBlock) are set (all-ones if the remainder is 0).
- After the last output handshake: return to IDLE and pulse `done_o`.
- `mem_ready_o` = in RUN, `beats_left`>0, and (output register empty or being drained this cycle).
- Beats beyond `beats_left` are never accepted.

## Timing
- The output register stage is registered. `vrf_valid_o` rises the cycle after the producing beat's handshake.
- Throughput: one word per cycle when `mem_valid_i` and `vrf_ready_i` are held high.
- Latency: offset=0, 1 cycle after beat 0. offset≠0, 1 cycle after beat 1 (or TAIL cycle when only one beat).
- `vrf_valid_o`, once high, holds with stable data/strobe until `vrf_ready_i`.
- A new request is accepted no earlier than the cycle after `done_o`.
- Reset values: `req_ready_o`=1, `mem_ready_o`=0, `vrf_valid_o`=0, `done_o`=0, data/strobe 0, counters 0, holder empty, state IDLE.
- Reset mid-operation discards all buffered bytes immediately.
- NrLane=1: shuffle is identity; realignment is unchanged.

## Structure
- `rvv_pkg`: `shuffle_idx(nr_lane, sew, k)` function and `lsu_state_e` enum.
- `core_pkg`: `ByteBlock` is already there.
- Sub-module `mem_shuffler`: purely combinational byte/strobe permutation (data, strobe, sew in; data, strobe out). It is instantiated once before the output register.

## Test plan
- NrLane=4, EW8, offset 0, bytes 64, beats bytes 0..63 → 2 words.
  - Word 0: lane0 bytes {0,4,8,...,28}, lane1 {1,5,...}.
  - Strobes all-ones; `done_o` on the 2nd handshake.
- NrLane=4, EW32, offset 4, bytes 40 → 2 memory beats, 2 words.
  - Word 1 strobe set only for aligned bytes 0..7: lane0 bytes 0-3 and lane1 bytes 0-3.
- NrLane=2, EW16, offset 12, bytes 2 → 1 beat, word emitted in TAIL.
  - Aligned bytes 0-1 = mem bytes 12-13, at lane0 bytes 0-1.
- Random `vrf_ready_i` (50%) with 8 words → no data loss or duplication; `mem_ready_o` low while the output is stalled.
- `req_bytes_i`=0 → no memory handshake, `vrf_valid_o` stays 0, `done_o` pulses once.
- Assert `rst_ni` low mid-RUN, then issue a fresh request → outputs at reset values; the new load is correct with no stale holder bytes.
